image_rom_arbiter: RTL and testbench
====================================

// Module: image_rom_arbiter
// PURPOSE
// - Shares one synchronous image ROM (4096 x 12 bit, 1-cycle registered read,
//   address = {y[5:0], x[5:0]}) between N_REQ sprite draw units.
// - Round-robin arbitration, at most one ROM access per clock.
// - Optional burst lock lets one drawer stream a scanline.
// - Returns each ROM word tagged with the id of the requester that issued it.
// - Sits between the obstacle/sprite renderers and the image ROM instance.
// PARAMETERS
// - N_REQ      4   number of requesters, 2..8
// - AW         12  ROM address width
// - DW         12  ROM data width (RGB 4:4:4)
// - MAX_BURST  16  max consecutive grants to one locked requester, 1..255
// - IDW        derived = $clog2(N_REQ); not overridable
// PORTS
// - clk        in   1          system clock, all logic on rising edge
// - rst_n      in   1          asynchronous, active-low reset
// - req        in   N_REQ      per-requester access request; held until gnt
// - lock       in   N_REQ      per-requester burst lock; sampled with req
// - addr_flat  in   N_REQ*AW   requester i address at [i*AW +: AW]
// - gnt        out  N_REQ      one-hot grant, same cycle as accepted req
// - rom_addr   out  AW         address to ROM; equals granted requester addr
// - rom_rgb    in   DW         ROM read data, valid 1 cycle after rom_addr
// - rsp_valid  out  1          rsp_rgb/rsp_id hold a returned ROM word
// - rsp_id     out  IDW        index of requester owning rsp_rgb
// - rsp_rgb    out  DW         returned pixel data
// BEHAVIOUR
// - Reset (rst_n=0, async): rr_ptr=0, owner=none, burst_cnt=0, tag pipe cleared;
//   gnt=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rom_addr=0.
// - Arbitration (combinational from req and registered state):
//   - Owner locked: if owner's req=1 and lock=1 and burst_cnt<MAX_BURST, grant owner.
//   - Otherwise grant the first req bit searching from rr_ptr upward, modulo N_REQ.
//   - No req: gnt=0, rom_addr=0, nothing issued.
// - On grant to i:
//   - rr_ptr <= (i+1) mod N_REQ.
//   - If lock[i]=1, owner <= i and burst_cnt <= (i==owner ? burst_cnt+1 : 1).
//     Otherwise owner <= none and burst_cnt <= 0.
// - Burst limit: when burst_cnt reaches MAX_BURST, owner is released and normal
//   round-robin applies that cycle. rr_ptr already skips past i, so others are
//   served before i again.
// - Owner drops req: lock is released immediately; round-robin resumes the same cycle.
// - Issue: requester sees gnt[i]=1 in cycle t, addr is consumed, and the requester
//   may change addr/req at t+1.
// - Response: tag pipe registers {issued, id}; rsp_valid=1 at t+1 (default
//   latency 1) with rsp_rgb=rom_rgb and rsp_id=i.
//   - rsp_valid is 0 in any cycle following a no-grant cycle.
//   - rsp_rgb holds its last value when rsp_valid=0.
// - Throughput: one grant per cycle sustained, no bubbles on back-to-back requests.
// - Mid-operation reset: in-flight tags are discarded and no rsp_valid follows.
// - Addresses are passed unmodified; no wrap or range check (full 4096 space).
// CONFIGURATION
// - Macro IMG_ROM_ARB_RSP_REG_EN:
//   - Defined: adds one output register stage; rsp_valid/rsp_id/rsp_rgb arrive
//     at t+2. The tag pipe is 2 deep. Reset values are unchanged.
//   - Undefined: latency 1 as above.
// TESTING
// - Reset then idle, req=0 -> gnt=0, rsp_valid=0, rsp_rgb=0 for 10 cycles.
// - req=4'b1111 held, lock=0, distinct addrs -> gnt cycles 0,1,2,3,0.
//   Each rsp_id matches the grant 1 cycle earlier; rsp_rgb=rom[addr].
// - req0=1 with lock0=1, req2=1, MAX_BURST=16 -> 16 consecutive gnt[0].
//   Then gnt[2] once, then gnt[0] resumes with burst_cnt=1.
// - Single req[3] pulse with addr=12'hABC -> gnt[3]=1 for 1 cycle.
//   Next cycle: rsp_valid=1, rsp_id=3, rsp_rgb=rom[12'hABC].
// - rst_n asserted the cycle after a grant -> rsp_valid stays 0, rr_ptr=0.
//   First grant after release goes to the lowest requesting index.
// - With IMG_ROM_ARB_RSP_REG_EN, rerun the round-robin test.
//   Same id/data order, each response exactly 2 cycles after its grant.

Source files
------------

// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM among N_REQ sprite drawers, with burst lock and id-tagged responses.
// Optional macro IMG_ROM_ARB_RSP_REG_EN adds an output register stage (response latency 2 instead of 1).
`timescale 1ns/1ps

module image_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AW        = 12,
  parameter int DW        = 12,
  parameter int MAX_BURST = 16,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  logic [N_REQ*AW-1:0]   addr_flat,
  output logic [N_REQ-1:0]      gnt,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_rgb,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [DW-1:0]         rsp_rgb
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IDW-1:0]     r_rr_ptr;
  logic               r_owner_vld;
  logic [IDW-1:0]     r_owner_id;
  logic [CW-1:0]      r_burst_cnt;
  logic               r_tag_vld;
  logic [IDW-1:0]     r_tag_id;

  logic [2*N_REQ-1:0] w_req_dbl;
  logic [N_REQ-1:0]   w_req_rot;
  logic               w_rot_hit;
  logic [IDW-1:0]     w_rot_ofs;
  logic [IDW:0]       w_rr_sum;
  logic [IDW-1:0]     w_rr_id;
  logic               w_hold;
  logic               w_gnt_vld;
  logic [IDW-1:0]     w_gnt_id;

  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  assign w_req_dbl = {req, req};
  assign w_req_rot = N_REQ'(w_req_dbl >> r_rr_ptr);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_rot_hit = 1'b0;
    w_rot_ofs = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_rot_hit = 1'b1;
        w_rot_ofs = IDW'(k);
      end
    end
  end

  assign w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rot_ofs};
  assign w_rr_id  = (w_rr_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_rr_sum - (IDW+1)'(N_REQ))
                                                   : IDW'(w_rr_sum);

  assign w_hold    = r_owner_vld && req[r_owner_id] && lock[r_owner_id] &&
                     (r_burst_cnt < CW'(MAX_BURST));
  assign w_gnt_vld = rst_n && (w_hold || w_rot_hit);
  assign w_gnt_id  = w_hold ? r_owner_id : w_rr_id;
  assign gnt       = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;

  always_comb begin
    rom_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) rom_addr = addr_flat[k*AW +: AW];
    end
  end

  // A lock grant that did not come through the hold path (fresh owner, or owner
  // re-won by round-robin after exhausting its burst) starts a new burst at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_rr_ptr    <= '0;
      r_owner_vld <= 1'b0;
      r_owner_id  <= '0;
      r_burst_cnt <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr <= (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      if (lock[w_gnt_id]) begin
        r_owner_vld <= 1'b1;
        r_owner_id  <= w_gnt_id;
        r_burst_cnt <= w_hold ? r_burst_cnt + 1'b1 : CW'(1);
      end else begin
        r_owner_vld <= 1'b0;
        r_burst_cnt <= '0;
      end
    end else begin
      r_owner_vld <= 1'b0;
      r_burst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= 1'b0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= w_gnt_vld;
      if (w_gnt_vld) r_tag_id <= w_gnt_id;
    end
  end

`ifdef IMG_ROM_ARB_RSP_REG_EN
  logic           r_rsp_vld;
  logic [IDW-1:0] r_rsp_id;
  logic [DW-1:0]  r_rsp_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_rgb <= '0;
    end else begin
      r_rsp_vld <= r_tag_vld;
      if (r_tag_vld) begin
        r_rsp_id  <= r_tag_id;
        r_rsp_rgb <= rom_rgb;
      end
    end
  end

  assign rsp_valid = r_rsp_vld;
  assign rsp_id    = r_rsp_id;
  assign rsp_rgb   = r_rsp_rgb;
`else
  logic [DW-1:0] r_rgb_hold;

  // ROM data is only valid for one cycle; keep a copy so rsp_rgb holds between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_hold <= '0;
    end else if (r_tag_vld) begin
      r_rgb_hold <= rom_rgb;
    end
  end

  assign rsp_valid = r_tag_vld;
  assign rsp_id    = r_tag_id;
  assign rsp_rgb   = r_tag_vld ? rom_rgb : r_rgb_hold;
`endif

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Self-checking bench for image_rom_arbiter: spec-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_image_rom_arbiter;

  localparam int N_REQ     = 4;
  localparam int AW        = 12;
  localparam int DW        = 12;
  localparam int MAX_BURST = 16;
`ifdef IMG_ROM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ*AW-1:0] addr_flat;
  logic [N_REQ-1:0]    gnt;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_rgb = '0;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [DW-1:0]       rsp_rgb;

  int n_cmp = 0;
  int n_bad = 0;

  image_rom_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr_flat(addr_flat),
    .gnt(gnt), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a ^ 12'h5A5;
  endfunction

  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- spec-level model ----------------
  int             m_rr = 0;
  int             m_owner = -1;
  int             m_cnt = 0;
  logic           h_vld [0:LAT];
  int             h_id  [0:LAT];
  logic [AW-1:0]  h_addr[0:LAT];
  logic [DW-1:0]  m_last = '0;

  function automatic bit bit_of(input logic [N_REQ-1:0] v, input int i);
    return ((v >> i) & N_REQ'(1)) != 0;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(addr_flat >> (i * AW));
  endfunction

  function automatic int model_pick();
    if (m_owner >= 0 && bit_of(req, m_owner) && bit_of(lock, m_owner) && m_cnt < MAX_BURST)
      return m_owner;
    for (int k = 0; k < N_REQ; k++)
      if (bit_of(req, (m_rr + k) % N_REQ)) return (m_rr + k) % N_REQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [N_REQ-1:0] eg;
    logic [AW-1:0] ea;
    if (!rst_n) begin
      m_rr = 0; m_owner = -1; m_cnt = 0; m_last = '0;
      for (int k = 0; k <= LAT; k++) begin h_vld[k] = 1'b0; h_id[k] = 0; h_addr[k] = '0; end
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rom_addr", 32'(rom_addr), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_rgb", 32'(rsp_rgb), 32'h0);
    end else begin
      g  = model_pick();
      eg = (g >= 0) ? N_REQ'(1 << g) : '0;
      ea = (g >= 0) ? addr_of(g) : '0;
      check("gnt", 32'(gnt), 32'(eg));
      check("rom_addr", 32'(rom_addr), 32'(ea));
      for (int k = LAT; k >= 1; k--) begin
        h_vld[k] = h_vld[k-1]; h_id[k] = h_id[k-1]; h_addr[k] = h_addr[k-1];
      end
      h_vld[0] = (g >= 0); h_id[0] = g; h_addr[0] = ea;
      check("rsp_valid", 32'(rsp_valid), 32'(h_vld[LAT]));
      if (h_vld[LAT]) begin
        m_last = rom_fn(h_addr[LAT]);
        check("rsp_id", 32'(rsp_id), 32'(h_id[LAT]));
      end
      check("rsp_rgb", 32'(rsp_rgb), 32'(m_last));
      if (g >= 0) begin
        m_rr = (g + 1) % N_REQ;
        if (bit_of(lock, g)) begin
          m_cnt   = (g == m_owner && m_cnt < MAX_BURST) ? m_cnt + 1 : 1;
          m_owner = g;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N_REQ-1:0] rr_g [0:4];
  logic [N_REQ-1:0] bg   [0:19];

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; addr_flat = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {gnt, 3'b0, rsp_valid, rsp_rgb, 2'b0, rsp_id}, 32'h0);
      tick();
    end

    // Plain round-robin over all four requesters.
    addr_flat = {12'h430, 12'h320, 12'h210, 12'h100};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rr_g[i] = gnt;
      tick();
    end
    req = '0;
    check("rr_seq0", 32'(rr_g[0]), 32'h1);
    check("rr_seq1", 32'(rr_g[1]), 32'h2);
    check("rr_seq2", 32'(rr_g[2]), 32'h4);
    check("rr_seq3", 32'(rr_g[3]), 32'h8);
    check("rr_seq4", 32'(rr_g[4]), 32'h1);
    repeat (3) tick();

    // Single pulse from requester 3.
    addr_flat = {12'hABC, 36'h0};
    req = 4'b1000;
    @(negedge clk);
    check("pulse_gnt", 32'(gnt), 32'h8);
    check("pulse_rom_addr", 32'(rom_addr), 32'hABC);
    tick();
    req = '0;
    repeat (LAT - 1) tick();
    @(negedge clk);
    check("pulse_rsp_valid", 32'(rsp_valid), 32'h1);
    check("pulse_rsp_id", 32'(rsp_id), 32'h3);
    check("pulse_rsp_rgb", 32'(rsp_rgb), 32'hF19);
    repeat (3) tick();

    // Burst lock by requester 0 while requester 2 waits.
    for (int k = 0; k < 20; k++) begin
      lock = 4'b0001;
      req  = 4'b0101;
      addr_flat = {12'h000, 12'h5E0, 12'h000, 12'(12'h7C0 + k)};
      @(negedge clk);
      bg[k] = gnt;
      tick();
    end
    req = '0; lock = '0;
    for (int k = 0; k < 16; k++) check("burst_owner", 32'(bg[k]), 32'h1);
    check("burst_other", 32'(bg[16]), 32'h4);
    check("burst_resume", 32'(bg[17]), 32'h1);
    check("burst_resume2", 32'(bg[18]), 32'h1);
    repeat (3) tick();

    // Reset right after a grant: tag dropped, rr_ptr back to 0.
    addr_flat = {12'h000, 12'h000, 12'h123, 12'h000};
    req = 4'b0010;
    @(negedge clk);
    check("prerst_gnt", 32'(gnt), 32'h2);
    tick();
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    addr_flat = {12'h789, 12'h000, 12'h456, 12'h000};
    req = 4'b1010;
    @(negedge clk);
    check("postrst_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0;
    repeat (LAT + 3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
